// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the byte-serial SubWord stage: FSM encodings, AES
// constants and the GF(2^8) helpers behind the Sbox.
package aes_sbox_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX_AFFINE_C  = 8'h63;
  localparam logic [7:0] SBOX_IAFFINE_C = 8'h05;
  localparam int         AES_WORD_BYTES = 4;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < 6; k++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] b;
    for (int k = 0; k < 8; k++)
      b[k] = x[3'(k)] ^ x[3'(k + 4)] ^ x[3'(k + 5)] ^ x[3'(k + 6)] ^ x[3'(k + 7)]
             ^ SBOX_AFFINE_C[k];
    return b;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] b;
    for (int k = 0; k < 8; k++)
      b[k] = x[3'(k + 2)] ^ x[3'(k + 5)] ^ x[3'(k + 7)] ^ SBOX_IAFFINE_C[k];
    return b;
  endfunction

endpackage

// File: rtl/aes_subword_serial_sbox.sv
// Single combinational AES S-box, forward or inverse selected per cycle.
module Sbox
  import aes_sbox_pkg::*;
(
  input  logic [7:0] i,
  input  logic       inverse,
  output logic [7:0] o
);

  assign o = inverse ? gf_inv(inv_affine(i)) : affine(gf_inv(i));

endmodule

// File: rtl/aes_subword_serial.sv
// Byte-serial SubWord: streams one word's bytes through a single Sbox, one
// byte per cycle, and hands the substituted word downstream over valid/ready.
module aes_subword_serial
  import aes_sbox_pkg::*;
#(
  parameter int BYTES = AES_WORD_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               in_inverse,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BYTES-1:0] out_data,
  output logic               out_inverse
);

  localparam int            CW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BYTES - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [8*BYTES-1:0] src_q, src_d;
  logic [8*BYTES-1:0] res_q, res_d;
  logic               mode_q, mode_d;
  logic               out_inv_q, out_inv_d;
  logic [7:0]         sbox_in;
  logic [7:0]         sbox_out;

  always_comb begin
    sbox_in = 8'h00;
    for (int k = 0; k < BYTES; k++)
      if (cnt_q == CW'(k)) sbox_in = src_q[8*k +: 8];
  end

  Sbox u_sbox (
    .i       (sbox_in),
    .inverse (mode_q),
    .o       (sbox_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    mode_d    = mode_q;
    res_d     = res_q;
    out_inv_d = out_inv_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_data;
          mode_d  = in_inverse;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < BYTES; k++)
          if (cnt_q == CW'(k)) res_d[8*k +: 8] = sbox_out;
        // cnt holds at the last byte index so it never wraps.
        if (cnt_q == CNT_LAST) begin
          out_inv_d = mode_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      src_q     <= '0;
      res_q     <= '0;
      mode_q    <= 1'b0;
      out_inv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      res_q     <= res_d;
      mode_q    <= mode_d;
      out_inv_q <= out_inv_d;
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = (state_q == DONE);
  assign out_data    = res_q;
  assign out_inverse = out_inv_q;

endmodule
